// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative mul/div/madd/msub producing {hi,lo}; ports clk reset flush, in_valid/in_ready op a b acc_hi acc_lo, out_valid/out_ready hi lo; MULDIV_FAST_MUL_EN selects single-cycle multiply
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
  state_t             state;
  logic [2:0]         op_r;
  logic               sa, sb, dz;
  logic [WIDTH-1:0]   ma, mb;
  logic [2*WIDTH-1:0] acc, prod;
  logic [CW-1:0]      cnt;
  logic               in_signed, in_mul, is_mul;
  logic [WIDTH-1:0]   ma_in, mb_in, quo, rem, div_hi, div_lo;
  logic [WIDTH:0]     div_sh, div_diff;
  logic [2*WIDTH-1:0] div_next, p_signed, mul_res, fix_res;
`ifndef MULDIV_FAST_MUL_EN
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] mul_next;
`endif
  always_comb begin
    in_ready  = state == IDLE;
    in_signed = ~op[0];
    in_mul    = op[2] | ~op[1];
    ma_in     = (in_signed & a[WIDTH-1]) ? -a : a;
    mb_in     = (in_signed & b[WIDTH-1]) ? -b : b;
    is_mul    = op_r[2] | ~op_r[1];
    div_sh    = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    div_diff  = div_sh - {1'b0, mb};
    div_next  = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], prod[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
    quo       = prod[WIDTH-1:0];
    rem       = prod[2*WIDTH-1:WIDTH];
    div_lo    = dz ? '1 : ((sa ^ sb) ? -quo : quo);
    div_hi    = sa ? -rem : rem;
    p_signed  = (sa ^ sb) ? -prod : prod;
    mul_res   = op_r[2] ? (op_r[1] ? acc - p_signed : acc + p_signed) : p_signed;
    fix_res   = is_mul ? mul_res : {div_hi, div_lo};
  end
`ifndef MULDIV_FAST_MUL_EN
  always_comb begin
    add_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, ma} : '0);
    mul_next = {add_sum, prod[WIDTH-1:1]};
  end
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_r      <= '0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      dz        <= 1'b0;
      ma        <= '0;
      mb        <= '0;
      acc       <= '0;
      prod      <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_r  <= op;
          sa    <= in_signed & a[WIDTH-1];
          sb    <= in_signed & b[WIDTH-1];
          dz    <= b == '0;
          ma    <= ma_in;
          mb    <= mb_in;
          acc   <= {acc_hi, acc_lo};
          prod  <= {{WIDTH{1'b0}}, in_mul ? mb_in : ma_in};
          cnt   <= '0;
          state <= in_mul ? MUL : DIV;
        end
        MUL: begin
`ifdef MULDIV_FAST_MUL_EN
          prod  <= {{WIDTH{1'b0}}, ma} * {{WIDTH{1'b0}}, mb};
          state <= FIX;
`else
          prod  <= mul_next;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
`endif
        end
        DIV: begin
          prod <= div_next;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          {hi, lo}  <= fix_res;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed scoreboard bench for muldiv_unit
module tb_muldiv_unit;
  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int ML = 2;
`else
  localparam int ML = W + 1;
`endif
  localparam int DL = W + 1;
  typedef struct {
    logic [W-1:0] h;
    logic [W-1:0] l;
    int           lat;
    int           acc;
    string        nm;
  } exp_t;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0, b = '0, acc_hi = '0, acc_lo = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] hi, lo;
  exp_t         sb_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .acc_hi(acc_hi), .acc_lo(acc_lo),
    .out_valid(out_valid), .out_ready(out_ready), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask
  initial begin
    bit   seen;
    exp_t e;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && !seen) begin
        seen = 1'b1;
        if (sb_q.size() == 0) chk("unexpected_out", 1, 0);
        else chk({sb_q[0].nm, "_latency"}, cyc - sb_q[0].acc, sb_q[0].lat);
      end
      if (out_valid && out_ready) begin
        seen = 1'b0;
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk({e.nm, "_hi"}, hi, e.h);
          chk({e.nm, "_lo"}, lo, e.l);
        end
      end
    end
  end
  task automatic issue(input string nm, input logic [2:0] o, input logic [W-1:0] ia, ib, ah, al,
                       input logic [W-1:0] eh, el, input int lat);
    int n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk({nm, "_ready_timeout"}, 0, 1);
      return;
    end
    op = o; a = ia; b = ib; acc_hi = ah; acc_lo = al; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb_q.push_back('{h: eh, l: el, lat: lat, acc: cyc, nm: nm});
  endtask
  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", sb_q.size(), 0);
  endtask
  initial begin
    logic [W-1:0] h0, l0;
    bit           saw;
    int           n;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    issue("mult",     3'b000, 32'hFFFFFFFD, 32'h00000005, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFF1, ML);
    issue("multu",    3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFE, 32'h00000001, ML);
    issue("div_neg",  3'b010, 32'hFFFFFFF9, 32'h00000002, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, DL);
    issue("divu",     3'b011, 32'h00000007, 32'h00000002, 0, 0, 32'h00000001, 32'h00000003, DL);
    issue("div_ovf",  3'b010, 32'h80000000, 32'hFFFFFFFF, 0, 0, 32'h00000000, 32'h80000000, DL);
    issue("divu_z",   3'b011, 32'h12345678, 32'h00000000, 0, 0, 32'h12345678, 32'hFFFFFFFF, DL);
    issue("div_z",    3'b010, 32'hFFFFFFF9, 32'h00000000, 0, 0, 32'hFFFFFFF9, 32'hFFFFFFFF, DL);
    issue("div_nb",   3'b010, 32'h00000007, 32'hFFFFFFFE, 0, 0, 32'h00000001, 32'hFFFFFFFD, DL);
    issue("maddu",    3'b101, 32'h00000001, 32'h00000001, 32'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, ML);
    issue("msub",     3'b110, 32'h00000001, 32'h00000001, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, ML);
    issue("madd",     3'b100, 32'hFFFFFFFE, 32'h00000003, 32'h0, 32'h10, 32'h00000000, 32'h0000000A, ML);
    issue("msubu",    3'b111, 32'h00000002, 32'h00000003, 32'h1, 32'h0, 32'h00000000, 32'hFFFFFFFA, ML);
    drain();
    op = 3'b010; a = 32'h00000064; b = 32'h00000007; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    flush = 1'b1; in_valid = 1'b1; op = 3'b001;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_in_ready", in_ready, 1);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_hi_hold", hi, 32'h00000000);
    chk("flush_lo_hold", lo, 32'hFFFFFFFA);
    saw = 1'b0;
    repeat (W + 5) begin
      @(posedge clk); #1;
      if (out_valid) saw = 1'b1;
    end
    chk("flush_no_result", saw, 0);
    chk("flush_idle", in_ready, 1);
    out_ready = 1'b0;
    issue("bp_multu", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFE, 32'h00000001, ML);
    n = 0;
    while (!out_valid && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_out_valid", out_valid, 1);
    h0 = hi; l0 = lo;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_hi", hi, h0);
      chk("bp_hold_lo", lo, l0);
    end
    out_ready = 1'b1;
    drain();
    @(posedge clk); #1;
    chk("post_hs_hi_hold", hi, 32'hFFFFFFFE);
    chk("post_hs_lo_hold", lo, 32'h00000001);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst2_hi", hi, 0);
    chk("rst2_lo", lo, 0);
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_in_ready", in_ready, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
